vga_term_ctrl: RTL and testbench
================================

Name: vga_term_ctrl

Overview:
Text-console controller that owns the write side of the terminal character RAM scanned by the VGA text renderer. It accepts a byte stream through a valid/ready handshake and tracks a cursor. It writes printable characters into the RAM and interprets control codes (LF, CR, BS, FF). It sequences multi-cycle clear and scroll-up operations through a second RAM read port; the renderer's own read port is untouched.

Parameters:
term_w, 70, characters per row
term_h, 30, rows on screen; term_w*term_h must be <= 2**addr_w
addr_w, 12, RAM address width, matching the renderer's charidx
blank_char, 8'h20, fill code for clear, scroll fill and backspace

Ports:
clk_50M  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  byte offered
in_char  in  8  byte value
in_ready  out  1  controller can accept; a transfer occurs when in_valid && in_ready at a rising edge
mem_we  out  1  RAM write enable, registered
mem_waddr  out  addr_w  RAM write address, registered
mem_wdata  out  8  RAM write data, registered
mem_raddr  out  addr_w  RAM read address for scroll copy
mem_rdata  in  8  RAM read data, valid exactly 1 cycle after mem_raddr
cursor_idx  out  addr_w  linear cursor position, row*term_w+col
busy  out  1  high in CLEAR, SCROLL_COPY and SCROLL_FILL

Behaviour:
- Reset values: mem_we=0, mem_waddr=0, mem_wdata=blank_char, mem_raddr=0, cursor_idx=0, col=0, row=0, in_ready=0, busy=1.
- On reset release the FSM enters CLEAR. There is no partial state retention.
- States and transitions:
  - IDLE: in_ready=1.
  - CLEAR: writes blank_char to addresses 0..term_w*term_h-1, one per cycle, then goes to IDLE with cursor=0.
  - SCROLL_COPY: for i=0..(term_h-1)*term_w-1, drives mem_raddr=i+term_w. It writes mem_rdata to address i one cycle later (pipelined), so copy length is (term_h-1)*term_w+1 cycles.
  - SCROLL_FILL: writes blank_char to the last row, (term_h-1)*term_w..term_h*term_w-1, then goes to IDLE with cursor at row term_h-1, col 0.
- in_ready = (state==IDLE). in_ready is combinational from the state register only and never depends on in_valid.
- Accepted byte (edge t), with mem_we/addr/data driven in cycle t+1 for one cycle:
  - 0x20..0xFF printable: write in_char at cursor_idx.
    - If col<term_w-1: col++.
    - Else wrap: col=0. If row<term_h-1 then row++; otherwise enter SCROLL_COPY.
  - 0x0A LF: col=0. If row<term_h-1 then row++, else SCROLL_COPY. No write.
  - 0x0D CR: col=0, no write.
  - 0x08 BS: if col>0, col-- and write blank_char at the new position. At col=0 it is a no-op.
  - 0x0C FF: enter CLEAR; the cursor resets to 0 when CLEAR completes.
  - Other codes below 0x20 are accepted and ignored.
- Throughput: one printable byte per cycle in IDLE. Back-to-back bytes are legal.
- The byte that causes the scroll is written before the scroll starts. Its write in cycle t+1 overlaps the first SCROLL_COPY read, which is legal because the addresses differ.
- cursor_idx is maintained incrementally (row base += term_w). No multiplier is used.
- cursor_idx updates on the same edge as col/row.
- Asserting rst_n low in any state, including mid-scroll, aborts the operation immediately. Outputs return to reset values and CLEAR reruns on release.
- While busy=1, in_valid and in_char are ignored. The upstream holds them per the handshake.

Decomposition:
- Shared package vga_term_pkg holds:
  - default term_w, term_h, addr_w and blank_char
  - control-code constants CH_LF, CH_CR, CH_BS, CH_FF
  - FSM state encoding (IDLE, CLEAR, SCROLL_COPY, SCROLL_FILL)
- One natural sub-module, term_cursor:
  - owns col, row and cursor_idx
  - commands: inc, dec, cr, lf, home, set_last_row
  - outputs flags at_last_col and at_last_row

Test Plan:
- Reset, then release -> busy=1 for 2100 cycles with mem_we=1 writing 0x20 at addresses 0..2099 in order, then in_ready=1 and cursor_idx=0.
- Stream "AB" back-to-back -> writes 0x41@0 then 0x42@1 on consecutive cycles; cursor_idx=2.
- 70 printable bytes then 0x0A on row 0 -> last write at 69; after the 70th byte cursor_idx=70 and no scroll. LF then moves the cursor to 140 and nothing is written.
- Cursor at row 29 col 5, send 0x0A -> busy rises; addresses 0..2029 receive the old contents of 70..2099; addresses 2030..2099 become 0x20; cursor_idx=2030; in_ready returns after 2101 busy cycles.
- Cursor at 75, send 0x08 then 0x08 at col 0 (cursor 70) -> first writes 0x20@74 with cursor 74; at 70 a BS produces no write and cursor stays 70.
- rst_n pulsed low mid-scroll at copy index 500 -> mem_we=0 immediately, cursor_idx=0, a full CLEAR follows, and a post-clear read-back is all 0x20.

Source files
------------

// File: rtl/vga_term_pkg.sv
// Shared defaults, control codes and FSM encoding for the terminal write-side controller.
package vga_term_pkg;

    localparam int unsigned def_term_w     = 70;
    localparam int unsigned def_term_h     = 30;
    localparam int unsigned def_addr_w     = 12;
    localparam logic [7:0]  def_blank_char = 8'h20;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CLEAR       = 2'd1,
        SCROLL_COPY = 2'd2,
        SCROLL_FILL = 2'd3
    } state_e;

endpackage

// File: rtl/vga_term_if.sv
// Byte stream, character RAM write/read ports and status of the terminal controller.
interface vga_term_if #(parameter int unsigned addr_w = vga_term_pkg::def_addr_w);

    logic              in_valid;
    logic [7:0]        in_char;
    logic              in_ready;
    logic              mem_we;
    logic [addr_w-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [addr_w-1:0] mem_raddr;
    logic [7:0]        mem_rdata;
    logic [addr_w-1:0] cursor_idx;
    logic              busy;

    // master: byte source and RAM; slave: the controller
    modport master (
        output in_valid, in_char, mem_rdata,
        input  in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, cursor_idx, busy
    );

    modport slave (
        input  in_valid, in_char, mem_rdata,
        output in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, cursor_idx, busy
    );

endinterface

// File: rtl/term_cursor.sv
// Cursor tracker: column, row and linear index kept incrementally (row base steps by term_w).
module term_cursor
    import vga_term_pkg::*;
#(
    parameter int unsigned term_w = def_term_w,
    parameter int unsigned term_h = def_term_h,
    parameter int unsigned addr_w = def_addr_w
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic              cr,
    input  logic              lf,
    input  logic              home,
    input  logic              set_last_row,
    output logic [addr_w-1:0] cursor_idx,
    output logic              at_last_col,
    output logic              at_last_row,
    output logic              at_first_col
);

    localparam int unsigned col_w = $clog2(term_w);
    localparam int unsigned row_w = $clog2(term_h);
    localparam logic [addr_w-1:0] last_row_base = addr_w'((term_h - 1) * term_w);
    localparam logic [addr_w-1:0] row_step      = addr_w'(term_w);

    logic [col_w-1:0]  col;
    logic [row_w-1:0]  row;
    logic [addr_w-1:0] row_base;

    assign at_last_col  = (col == col_w'(term_w - 1));
    assign at_last_row  = (row == row_w'(term_h - 1));
    assign at_first_col = (col == '0);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            cursor_idx <= '0;
        end else if (home) begin
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            cursor_idx <= '0;
        end else if (set_last_row) begin
            col        <= '0;
            row        <= row_w'(term_h - 1);
            row_base   <= last_row_base;
            cursor_idx <= last_row_base;
        end else if ((inc && at_last_col) || lf || cr) begin
            col <= '0;
            // On the last row the scroll that follows repositions the cursor.
            if ((inc || lf) && !at_last_row) begin
                row        <= row + 1'b1;
                row_base   <= row_base + row_step;
                cursor_idx <= row_base + row_step;
            end else begin
                cursor_idx <= row_base;
            end
        end else if (inc) begin
            col        <= col + 1'b1;
            cursor_idx <= cursor_idx + 1'b1;
        end else if (dec && !at_first_col) begin
            col        <= col - 1'b1;
            cursor_idx <= cursor_idx - 1'b1;
        end
    end

endmodule

// File: rtl/vga_term_ctrl.sv
// Terminal controller: writes printable bytes, interprets LF/CR/BS/FF, sequences clear and scroll.
//
// state       | meaning
// IDLE        | accept one byte per cycle
// CLEAR       | blank every cell, then cursor home
// SCROLL_COPY | move rows 1..h-1 up one row via the read port (1-cycle read latency)
// SCROLL_FILL | blank the last row, then cursor to last row col 0
module vga_term_ctrl
    import vga_term_pkg::*;
#(
    parameter int unsigned term_w     = def_term_w,
    parameter int unsigned term_h     = def_term_h,
    parameter int unsigned addr_w     = def_addr_w,
    parameter logic [7:0]  blank_char = def_blank_char
) (
    input  logic     clk_50M,
    input  logic     rst_n,
    vga_term_if.slave bus
);

    localparam logic [addr_w-1:0] last_cell  = addr_w'(term_w * term_h - 1);
    localparam logic [addr_w-1:0] copy_last  = addr_w'((term_h - 1) * term_w);
    localparam logic [addr_w-1:0] fill_start = addr_w'((term_h - 1) * term_w);
    localparam logic [addr_w-1:0] row_step   = addr_w'(term_w);

    state_e            state, state_nxt;
    logic [addr_w-1:0] idx, idx_nxt;
    logic              we_nxt;
    logic [addr_w-1:0] waddr_nxt;
    logic [7:0]        wdata_nxt;
    logic              cur_inc, cur_dec, cur_cr, cur_lf, cur_home, cur_last;
    logic [addr_w-1:0] cursor_idx;
    logic              at_last_col, at_last_row, at_first_col;

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.cursor_idx = cursor_idx;
    assign bus.mem_raddr  = (state == SCROLL_COPY) ? idx + row_step : '0;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLEAR;
            idx           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= blank_char;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            bus.mem_we    <= we_nxt;
            bus.mem_waddr <= waddr_nxt;
            bus.mem_wdata <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        waddr_nxt = bus.mem_waddr;
        wdata_nxt = bus.mem_wdata;
        cur_inc   = 1'b0;
        cur_dec   = 1'b0;
        cur_cr    = 1'b0;
        cur_lf    = 1'b0;
        cur_home  = 1'b0;
        cur_last  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_char >= 8'h20) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = cursor_idx;
                        wdata_nxt = bus.in_char;
                        cur_inc   = 1'b1;
                        if (at_last_col && at_last_row) begin
                            state_nxt = SCROLL_COPY;
                            idx_nxt   = '0;
                        end
                    end else begin
                        case (bus.in_char)
                            CH_LF: begin
                                cur_lf = 1'b1;
                                if (at_last_row) begin
                                    state_nxt = SCROLL_COPY;
                                    idx_nxt   = '0;
                                end
                            end
                            CH_CR: cur_cr = 1'b1;
                            CH_BS: begin
                                if (!at_first_col) begin
                                    cur_dec   = 1'b1;
                                    we_nxt    = 1'b1;
                                    waddr_nxt = cursor_idx - 1'b1;
                                    wdata_nxt = blank_char;
                                end
                            end
                            CH_FF: begin
                                state_nxt = CLEAR;
                                idx_nxt   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                we_nxt    = 1'b1;
                waddr_nxt = idx;
                wdata_nxt = blank_char;
                idx_nxt   = idx + 1'b1;
                if (idx == last_cell) begin
                    state_nxt = IDLE;
                    cur_home  = 1'b1;
                end
            end
            SCROLL_COPY: begin
                // rdata now holds the cell read last cycle, which belongs one row up
                if (idx != '0) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = idx - 1'b1;
                    wdata_nxt = bus.mem_rdata;
                end
                idx_nxt = idx + 1'b1;
                if (idx == copy_last) begin
                    state_nxt = SCROLL_FILL;
                    idx_nxt   = fill_start;
                end
            end
            SCROLL_FILL: begin
                we_nxt    = 1'b1;
                waddr_nxt = idx;
                wdata_nxt = blank_char;
                idx_nxt   = idx + 1'b1;
                if (idx == last_cell) begin
                    state_nxt = IDLE;
                    cur_last  = 1'b1;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    term_cursor #(
        .term_w (term_w),
        .term_h (term_h),
        .addr_w (addr_w)
    ) u_cursor (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .inc          (cur_inc),
        .dec          (cur_dec),
        .cr           (cur_cr),
        .lf           (cur_lf),
        .home         (cur_home),
        .set_last_row (cur_last),
        .cursor_idx   (cursor_idx),
        .at_last_col  (at_last_col),
        .at_last_row  (at_last_row),
        .at_first_col (at_first_col)
    );

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl with a behavioural character RAM (1-cycle read latency).
module tb_vga_term_ctrl;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #10 clk_50M = ~clk_50M;

    vga_term_if #(.addr_w(12)) bus ();

    vga_term_ctrl #(
        .term_w     (70),
        .term_h     (30),
        .addr_w     (12),
        .blank_char (8'h20)
    ) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    logic [7:0]  ram  [4096] = '{default: 8'hFF};
    logic [7:0]  snap [4096];
    logic [31:0] wlog [$];

    always @(posedge clk_50M) begin
        if (bus.mem_we) begin
            ram[bus.mem_waddr] <= bus.mem_wdata;
            wlog.push_back(32'(bus.mem_waddr));
        end
        bus.mem_rdata <= ram[bus.mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < limit) begin
            cyc++;
            @(negedge clk_50M);
        end
    endtask

    // Drive one byte at this negedge; returns at the next negedge with in_valid still high.
    task automatic send(input logic [7:0] ch);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 5000) begin
            w++;
            @(negedge clk_50M);
        end
        if (w == 5000) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        @(negedge clk_50M);
    endtask

    task automatic count_nonblank(output int bad);
        bad = 0;
        for (int i = 0; i < 2100; i++)
            if (ram[i] !== 8'h20) bad++;
    endtask

    initial begin
        int cyc;
        int bad;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk_50M);

        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_waddr",  32'(bus.mem_waddr),  32'd0);
        check("rst_mem_wdata",  32'(bus.mem_wdata),  32'h20);
        check("rst_mem_raddr",  32'(bus.mem_raddr),  32'd0);
        check("rst_cursor_idx", 32'(bus.cursor_idx), 32'd0);
        check("rst_in_ready",   32'(bus.in_ready),   32'd0);
        check("rst_busy",       32'(bus.busy),       32'd1);

        // power-up clear
        rst_n = 1'b1;
        wlog.delete();
        wait_idle(5000, cyc);
        check("clear_busy_cycles", 32'(cyc), 32'd2100);
        check("clear_in_ready",    32'(bus.in_ready),   32'd1);
        check("clear_cursor",      32'(bus.cursor_idx), 32'd0);
        @(negedge clk_50M);
        check("clear_write_count", 32'(wlog.size()), 32'd2100);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] !== 32'(i)) bad++;
        check("clear_write_order", 32'(bad), 32'd0);
        count_nonblank(bad);
        check("clear_ram_blank", 32'(bad), 32'd0);

        // "AB" back-to-back
        send(8'h41);
        check("a_we",     32'(bus.mem_we),     32'd1);
        check("a_waddr",  32'(bus.mem_waddr),  32'd0);
        check("a_wdata",  32'(bus.mem_wdata),  32'h41);
        check("a_cursor", 32'(bus.cursor_idx), 32'd1);
        send(8'h42);
        check("b_we",     32'(bus.mem_we),     32'd1);
        check("b_waddr",  32'(bus.mem_waddr),  32'd1);
        check("b_wdata",  32'(bus.mem_wdata),  32'h42);
        check("b_cursor", 32'(bus.cursor_idx), 32'd2);
        bus.in_valid = 1'b0;
        @(negedge clk_50M);
        check("ab_idle_we", 32'(bus.mem_we), 32'd0);

        // rest of row 0, then LF
        for (int i = 2; i < 70; i++) send(8'(8'h61 + i % 26));
        check("row0_last_waddr", 32'(bus.mem_waddr),  32'd69);
        check("row0_last_wdata", 32'(bus.mem_wdata),  32'h72);
        check("row0_cursor",     32'(bus.cursor_idx), 32'd70);
        check("row0_no_scroll",  32'(bus.busy),       32'd0);
        send(8'h0A);
        bus.in_valid = 1'b0;
        check("lf_cursor",   32'(bus.cursor_idx), 32'd140);
        check("lf_no_write", 32'(bus.mem_we),     32'd0);
        check("lf_no_busy",  32'(bus.busy),       32'd0);

        // form feed
        send(8'h0C);
        bus.in_valid = 1'b0;
        wait_idle(5000, cyc);
        check("ff_busy_cycles", 32'(cyc), 32'd2100);
        check("ff_cursor",      32'(bus.cursor_idx), 32'd0);
        @(negedge clk_50M);

        // backspace at col 5 and at col 0
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        check("bs_setup_cursor", 32'(bus.cursor_idx), 32'd75);
        send(8'h08);
        check("bs_we",     32'(bus.mem_we),     32'd1);
        check("bs_waddr",  32'(bus.mem_waddr),  32'd74);
        check("bs_wdata",  32'(bus.mem_wdata),  32'h20);
        check("bs_cursor", 32'(bus.cursor_idx), 32'd74);
        for (int i = 0; i < 4; i++) send(8'h08);
        check("bs_back_to_col0", 32'(bus.cursor_idx), 32'd70);
        send(8'h08);
        check("bs_col0_no_write", 32'(bus.mem_we),     32'd0);
        check("bs_col0_cursor",   32'(bus.cursor_idx), 32'd70);

        // scroll from row 29 col 5
        for (int r = 1; r < 29; r++) begin
            send(8'(8'h41 + r));
            send(8'h0A);
        end
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i));
        bus.in_valid = 1'b0;
        check("scroll_setup_cursor", 32'(bus.cursor_idx), 32'd2035);
        repeat (2) @(negedge clk_50M);
        for (int i = 0; i < 4096; i++) snap[i] = ram[i];
        send(8'h0A);
        bus.in_valid = 1'b0;
        check("scroll_busy_rises", 32'(bus.busy), 32'd1);
        wait_idle(5000, cyc);
        check("scroll_busy_cycles", 32'(cyc), 32'd2101);
        check("scroll_cursor",      32'(bus.cursor_idx), 32'd2030);
        check("scroll_in_ready",    32'(bus.in_ready),   32'd1);
        @(negedge clk_50M);
        bad = 0;
        for (int i = 0; i < 2030; i++) if (ram[i] !== snap[i + 70]) bad++;
        for (int i = 2030; i < 2100; i++) if (ram[i] !== 8'h20) bad++;
        check("scroll_ram_image", 32'(bad), 32'd0);
        check("scroll_row27_col0", 32'(ram[1890]), 32'h5D);
        check("scroll_row28_col0", 32'(ram[1960]), 32'h70);
        check("scroll_row28_col4", 32'(ram[1964]), 32'h74);
        check("scroll_row29_col0", 32'(ram[2030]), 32'h20);

        // reset in the middle of a scroll copy
        send(8'h0A);
        bus.in_valid = 1'b0;
        repeat (500) @(negedge clk_50M);
        check("mid_copy_raddr", 32'(bus.mem_raddr), 32'd570);
        check("mid_copy_we",    32'(bus.mem_we),    32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we",       32'(bus.mem_we),     32'd0);
        check("abort_cursor",   32'(bus.cursor_idx), 32'd0);
        check("abort_raddr",    32'(bus.mem_raddr),  32'd0);
        check("abort_in_ready", 32'(bus.in_ready),   32'd0);
        check("abort_busy",     32'(bus.busy),       32'd1);
        @(negedge clk_50M);
        rst_n = 1'b1;
        wait_idle(5000, cyc);
        check("reclear_busy_cycles", 32'(cyc), 32'd2100);
        check("reclear_cursor",      32'(bus.cursor_idx), 32'd0);
        @(negedge clk_50M);
        count_nonblank(bad);
        check("reclear_ram_blank", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
